sensor_sequencer: RTL and testbench
===================================

SENSOR_SEQUENCER -- requirements
Module: sensor_sequencer

Interface
REQ-001 SHALL have parameter ERASE_CYCLES, default 5, erase phase length in clk cycles (1..255).
REQ-002 SHALL have parameter CONVERT_CYCLES, default 255, ADC conversion phase length (1..255).
REQ-003 SHALL have parameter READ_CYCLES, default 5, length of each row readout phase (1..255).
REQ-004 SHALL have parameter EXP_DEFAULT, default 16, exposure length after reset (2..63).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 init  in  1  start-of-frame request, sampled each cycle.
REQ-008 exp_inc  in  1  increment exposure length by one cycle.
REQ-009 exp_dec  in  1  decrement exposure length by one cycle.
REQ-010 exposecycles  out  6  current exposure length setting.
REQ-011 erase  out  1  pixel erase strobe.
REQ-012 expose  out  1  pixel exposure window.
REQ-013 convert  out  1  ADC conversion enable.
REQ-014 read_row1  out  1  row 1 readout select.
REQ-015 read_row2  out  1  row 2 readout select.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 frame_done  out  1  one-cycle pulse at end of frame.

Function
REQ-018 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, READ1, READ2; all outputs registered.
REQ-019 IDLE: init=1 -> ERASE next cycle; init outside IDLE ignored (no queuing).
REQ-020 ERASE: erase=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
REQ-021 On entry to EXPOSE, the exposure length SHALL be latched; expose=1 for exactly that many cycles, then CONVERT.
REQ-022 CONVERT: convert=1 for exactly CONVERT_CYCLES cycles, then READ1.
REQ-023 READ1/READ2: read_row1/read_row2 high for READ_CYCLES cycles each, READ1 -> READ2 -> IDLE.
REQ-024 Phase strobes SHALL be mutually exclusive and contiguous: last cycle of one phase is followed immediately by first cycle of the next (no gap cycles).
REQ-025 frame_done SHALL pulse high for one cycle coincident with the first IDLE cycle after READ2.
REQ-026 Exposure register SHALL update only in IDLE: exp_inc -> +1 saturating at 63; exp_dec -> -1 saturating at 2; both high -> unchanged.
REQ-027 exp_inc/exp_dec and init in the same IDLE cycle: register update takes effect and the new value is used for that frame.
REQ-028 exp_inc/exp_dec outside IDLE SHALL be ignored; exposecycles SHALL be stable during a frame.
REQ-029 Phase counter SHALL be 8 bits, loaded with phase length minus one on entry and decremented to zero.

Reset
REQ-030 reset SHALL force IDLE, exposecycles=EXP_DEFAULT, counter=0, and erase, expose, convert, read_row1, read_row2, busy, frame_done all 0, immediately and asynchronously.
REQ-031 Reset mid-frame SHALL abort the frame with no frame_done pulse; first post-reset clock with init=1 starts a fresh frame.

Structure
REQ-032 State enum, default phase lengths and exposure limits (2, 63) SHALL live in shared package sensor_pkg.
REQ-033 A single sub-module cycle_timer (loadable 8-bit down-counter with zero flag) SHALL provide phase timing.

Verification
REQ-034 Defaults, init pulse 1 cycle -> erase 5, expose 16, convert 255, row1 5, row2 5 cycles, contiguous; frame_done one cycle; busy 286 cycles.
REQ-035 In IDLE, 50 exp_inc pulses from 16 -> exposecycles=63; then 70 exp_dec pulses -> 2; next frame expose=2 cycles.
REQ-036 exp_inc and exp_dec simultaneously in IDLE -> exposecycles unchanged; exp_inc during EXPOSE -> unchanged, expose length unchanged.
REQ-037 init held high continuously -> back-to-back frames, each new ERASE starting the cycle after a frame_done-cycle with init sampled.
REQ-038 reset asserted in 3rd convert cycle -> all outputs 0 without waiting for clk edge, no frame_done, exposecycles=16.
REQ-039 init during READ1 -> ignored; sequence completes exactly once.

Source files
------------

// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_pkg
// Purpose  : Shared state encoding, default phase lengths and exposure limits
//            for the pixel-array frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ1   = 3'd4,
        ST_READ2   = 3'd5
    } state_e;

    localparam int c_erase_cycles_def   = 5;
    localparam int c_convert_cycles_def = 255;
    localparam int c_read_cycles_def    = 5;
    localparam int c_exp_default_def    = 16;

    localparam logic [5:0] c_exp_min = 6'd2;
    localparam logic [5:0] c_exp_max = 6'd63;

    // Saturating exposure step; opposing requests cancel each other.
    function automatic logic [5:0] exp_step(
        input logic [5:0] cur,
        input logic       inc,
        input logic       dec
    );
        logic [5:0] nxt;
        nxt = cur;
        if (inc && !dec && (cur < c_exp_max)) begin
            nxt = cur + 6'd1;
        end else if (dec && !inc && (cur > c_exp_min)) begin
            nxt = cur - 6'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_timer
// Purpose  : Loadable 8-bit down-counter that stops at zero and flags it.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_zero
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == 8'd0);

endmodule
`default_nettype wire

// File: rtl/sensor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sensor_sequencer
// Purpose  : Frame sequencer driving erase, expose, convert and two-row
//            readout strobes, with an IDLE-only adjustable exposure length.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_sequencer
    import sensor_pkg::*;
#(
    parameter int ERASE_CYCLES   = c_erase_cycles_def,
    parameter int CONVERT_CYCLES = c_convert_cycles_def,
    parameter int READ_CYCLES    = c_read_cycles_def,
    parameter int EXP_DEFAULT    = c_exp_default_def
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       exp_inc,
    input  logic       exp_dec,
    output logic [5:0] exposecycles,
    output logic       erase,
    output logic       expose,
    output logic       convert,
    output logic       read_row1,
    output logic       read_row2,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0] c_erase_load   = 8'(ERASE_CYCLES - 1);
    localparam logic [7:0] c_convert_load = 8'(CONVERT_CYCLES - 1);
    localparam logic [7:0] c_read_load    = 8'(READ_CYCLES - 1);
    localparam logic [5:0] c_exp_reset    = 6'(EXP_DEFAULT);

    state_e     state_q;
    state_e     state_d;
    logic [5:0] exp_q;
    logic [5:0] exp_d;

    logic       timer_load;
    logic [7:0] timer_load_val;
    logic       timer_zero;

    logic erase_q,     erase_d;
    logic expose_q,    expose_d;
    logic convert_q,   convert_d;
    logic read_row1_q, read_row1_d;
    logic read_row2_q, read_row2_d;
    logic busy_q,      busy_d;
    logic frame_done_q, frame_done_d;

    cycle_timer u_cycle_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (timer_load),
        .i_load_val (timer_load_val),
        .o_zero     (timer_zero)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; each phase entry loads its length minus one.
    always_comb begin
        state_d        = state_q;
        timer_load     = 1'b0;
        timer_load_val = 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (init) begin
                    state_d        = ST_ERASE;
                    timer_load     = 1'b1;
                    timer_load_val = c_erase_load;
                end
            end
            ST_ERASE: begin
                if (timer_zero) begin
                    // exp_q is frozen outside IDLE, so this load latches the frame's exposure.
                    state_d        = ST_EXPOSE;
                    timer_load     = 1'b1;
                    timer_load_val = {2'b00, exp_q} - 8'd1;
                end
            end
            ST_EXPOSE: begin
                if (timer_zero) begin
                    state_d        = ST_CONVERT;
                    timer_load     = 1'b1;
                    timer_load_val = c_convert_load;
                end
            end
            ST_CONVERT: begin
                if (timer_zero) begin
                    state_d        = ST_READ1;
                    timer_load     = 1'b1;
                    timer_load_val = c_read_load;
                end
            end
            ST_READ1: begin
                if (timer_zero) begin
                    state_d        = ST_READ2;
                    timer_load     = 1'b1;
                    timer_load_val = c_read_load;
                end
            end
            ST_READ2: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every strobe comes straight off a flop.
    always_comb begin
        erase_d      = (state_d == ST_ERASE);
        expose_d     = (state_d == ST_EXPOSE);
        convert_d    = (state_d == ST_CONVERT);
        read_row1_d  = (state_d == ST_READ1);
        read_row2_d  = (state_d == ST_READ2);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_q == ST_READ2) && (state_d == ST_IDLE);
    end

    always_comb begin
        exp_d = exp_q;
        if (state_q == ST_IDLE) begin
            exp_d = exp_step(exp_q, exp_inc, exp_dec);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q        <= c_exp_reset;
            erase_q      <= 1'b0;
            expose_q     <= 1'b0;
            convert_q    <= 1'b0;
            read_row1_q  <= 1'b0;
            read_row2_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            exp_q        <= exp_d;
            erase_q      <= erase_d;
            expose_q     <= expose_d;
            convert_q    <= convert_d;
            read_row1_q  <= read_row1_d;
            read_row2_q  <= read_row2_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign exposecycles = exp_q;
    assign erase        = erase_q;
    assign expose       = expose_q;
    assign convert      = convert_q;
    assign read_row1    = read_row1_q;
    assign read_row2    = read_row2_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_sequencer
// Purpose  : Directed self-checking bench for sensor_sequencer (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic       exp_inc;
    logic       exp_dec;
    logic [5:0] exposecycles;
    logic       erase, expose, convert, read_row1, read_row2, busy, frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    int cnt_erase, cnt_expose, cnt_convert, cnt_r1, cnt_r2, cnt_busy, cnt_done;
    int first_done, n_starts, bad_excl, bad_order, bad_exp;

    sensor_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .exp_inc      (exp_inc),
        .exp_dec      (exp_dec),
        .exposecycles (exposecycles),
        .erase        (erase),
        .expose       (expose),
        .convert      (convert),
        .read_row1    (read_row1),
        .read_row2    (read_row2),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Samples ncyc cycles at negedges; init/exp_inc pulses are injected for the
    // cycle following sample index init_at / inc_at.
    task automatic frame_window(input int ncyc, input bit hold_init, input int inc_at,
                                input int init_at, input logic [5:0] exp_expect);
        int   prev_idx;
        int   idx;
        int   nstrobe;
        logic prev_busy;
        cnt_erase = 0; cnt_expose = 0; cnt_convert = 0; cnt_r1 = 0; cnt_r2 = 0;
        cnt_busy = 0; cnt_done = 0; first_done = -1; n_starts = 0;
        bad_excl = 0; bad_order = 0; bad_exp = 0;
        prev_idx = 0; prev_busy = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            nstrobe = int'(erase) + int'(expose) + int'(convert) + int'(read_row1) + int'(read_row2);
            idx = erase ? 1 : expose ? 2 : convert ? 3 : read_row1 ? 4 : read_row2 ? 5 : 0;
            cnt_erase   += int'(erase);
            cnt_expose  += int'(expose);
            cnt_convert += int'(convert);
            cnt_r1      += int'(read_row1);
            cnt_r2      += int'(read_row2);
            cnt_busy    += int'(busy);
            if (busy ? (nstrobe != 1) : (nstrobe != 0)) bad_excl++;
            if (frame_done && busy) bad_excl++;
            if (busy && !prev_busy) begin
                n_starts++;
                if (idx != 1) bad_order++;
            end else if (busy && prev_busy && (idx < prev_idx || idx > prev_idx + 1)) begin
                bad_order++;
            end
            if (frame_done) begin
                cnt_done++;
                if (first_done < 0) first_done = i;
            end
            if (exposecycles !== exp_expect) bad_exp++;
            prev_idx  = idx;
            prev_busy = busy;
            init    = hold_init || (i == init_at);
            exp_inc = (i == inc_at);
            exp_dec = 1'b0;
        end
    endtask

    initial begin
        int drained;
        int seen;
        reset = 1'b1; init = 1'b0; exp_inc = 1'b0; exp_dec = 1'b0;
        #1;
        chk("reset_outputs", 32'({erase, expose, convert, read_row1, read_row2, busy, frame_done}), 32'd0);
        chk("reset_exp", 32'(exposecycles), 32'd16);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Default frame from a single-cycle init pulse
        init = 1'b1;
        frame_window(300, 1'b0, -1, -1, 6'd16);
        chk("dflt_erase",   32'(cnt_erase),   32'd5);
        chk("dflt_expose",  32'(cnt_expose),  32'd16);
        chk("dflt_convert", 32'(cnt_convert), 32'd255);
        chk("dflt_row1",    32'(cnt_r1),      32'd5);
        chk("dflt_row2",    32'(cnt_r2),      32'd5);
        chk("dflt_busy",    32'(cnt_busy),    32'd286);
        chk("dflt_done",    32'(cnt_done),    32'd1);
        chk("dflt_done_at", 32'(first_done),  32'd286);
        chk("dflt_starts",  32'(n_starts),    32'd1);
        chk("dflt_excl",    32'(bad_excl),    32'd0);
        chk("dflt_order",   32'(bad_order),   32'd0);
        chk("dflt_expstab", 32'(bad_exp),     32'd0);

        // Saturation at both ends
        for (int k = 0; k < 50; k++) begin
            exp_inc = 1'b1; @(negedge clk);
            exp_inc = 1'b0; @(negedge clk);
        end
        chk("exp_sat_hi", 32'(exposecycles), 32'd63);
        for (int k = 0; k < 70; k++) begin
            exp_dec = 1'b1; @(negedge clk);
            exp_dec = 1'b0; @(negedge clk);
        end
        chk("exp_sat_lo", 32'(exposecycles), 32'd2);
        init = 1'b1;
        frame_window(300, 1'b0, -1, -1, 6'd2);
        chk("min_expose",  32'(cnt_expose), 32'd2);
        chk("min_busy",    32'(cnt_busy),   32'd272);
        chk("min_done_at", 32'(first_done), 32'd272);

        // Opposing requests cancel; increment mid-EXPOSE is ignored
        exp_inc = 1'b1; exp_dec = 1'b1; @(negedge clk);
        exp_inc = 1'b0; exp_dec = 1'b0;
        chk("exp_both", 32'(exposecycles), 32'd2);
        exp_inc = 1'b1; @(negedge clk);
        exp_inc = 1'b0;
        chk("exp_inc1", 32'(exposecycles), 32'd3);
        init = 1'b1;
        frame_window(300, 1'b0, 6, -1, 6'd3);
        chk("midexp_expose",  32'(cnt_expose),   32'd3);
        chk("midexp_expstab", 32'(bad_exp),      32'd0);
        chk("midexp_after",   32'(exposecycles), 32'd3);

        // Increment together with init applies to that same frame
        init = 1'b1; exp_inc = 1'b1;
        frame_window(300, 1'b0, -1, -1, 6'd4);
        chk("same_expose", 32'(cnt_expose), 32'd4);
        chk("same_busy",   32'(cnt_busy),   32'd274);
        chk("same_expst",  32'(bad_exp),    32'd0);

        // init held high: back-to-back frames separated by the frame_done cycle
        init = 1'b1;
        frame_window(560, 1'b1, -1, -1, 6'd4);
        init = 1'b0;
        chk("b2b_starts",  32'(n_starts),   32'd3);
        chk("b2b_done",    32'(cnt_done),   32'd2);
        chk("b2b_done_at", 32'(first_done), 32'd274);
        chk("b2b_busy",    32'(cnt_busy),   32'd558);
        chk("b2b_excl",    32'(bad_excl),   32'd0);
        chk("b2b_order",   32'(bad_order),  32'd0);
        drained = 0;
        for (int k = 0; k < 400 && drained == 0; k++) begin
            @(negedge clk);
            if (frame_done) drained = 1;
        end
        chk("b2b_drain", 32'(drained), 32'd1);
        @(negedge clk);

        // init during READ1 is dropped
        init = 1'b1;
        frame_window(300, 1'b0, -1, 265, 6'd4);
        chk("r1init_starts", 32'(n_starts), 32'd1);
        chk("r1init_done",   32'(cnt_done), 32'd1);
        chk("r1init_row2",   32'(cnt_r2),   32'd5);
        chk("r1init_busy",   32'(cnt_busy), 32'd274);

        // Asynchronous reset in the third convert cycle
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (11) @(negedge clk);
        chk("rst_pre_convert", 32'(convert), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_outs", 32'({erase, expose, convert, read_row1, read_row2, busy, frame_done}), 32'd0);
        chk("rst_async_exp",  32'(exposecycles), 32'd16);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            seen += int'(frame_done) + int'(busy);
        end
        chk("rst_no_done", 32'(seen), 32'd0);
        init = 1'b1;
        frame_window(300, 1'b0, -1, -1, 6'd16);
        chk("rst_fresh_expose", 32'(cnt_expose), 32'd16);
        chk("rst_fresh_busy",   32'(cnt_busy),   32'd286);
        chk("rst_fresh_done",   32'(cnt_done),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
